// File: rtl/ped_crossing_unit.sv
// Pedestrian crossing controller: button synchronizer/debouncer, request/grant FSM,
// walk/flash timing with blink and buzzer cadence, all outputs registered.

module ped_crossing_unit_chk (
    input logic clk,
    input logic reset,
    input logic walk,
    input logic dont_walk,
    input logic busy,
    input logic ped_req
);

    a_lamp_excl: assert property (@(posedge clk) disable iff (reset) !(walk && dont_walk));

    a_busy_no_req: assert property (@(posedge clk) disable iff (reset) !(busy && ped_req));

    a_walk_busy: assert property (@(posedge clk) disable iff (reset) walk |-> busy);

endmodule

module ped_crossing_unit #(
    parameter int unsigned DEBOUNCE_CYC = 500000,
    parameter int unsigned WALK_CYC     = 250000000,
    parameter int unsigned FLASH_CYC    = 150000000,
    parameter int unsigned BLINK_HALF   = 12500000
) (
    input  logic clk,
    input  logic reset,
    input  logic ped_btn,
    input  logic green_in,
    output logic ped_req,
    output logic walk,
    output logic dont_walk,
    output logic buzzer,
    output logic busy
);

    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned DUR_MAX = (WALK_CYC > FLASH_CYC) ? WALK_CYC : FLASH_CYC;
    localparam int unsigned DUR_W   = $clog2(DUR_MAX + 1);
    localparam int unsigned BLK_W   = $clog2(BLINK_HALF + 1);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [DUR_W-1:0] WALK_LAST  = DUR_W'(WALK_CYC - 1);
    localparam logic [DUR_W-1:0] FLASH_LAST = DUR_W'(FLASH_CYC - 1);
    localparam logic [BLK_W-1:0] BLK_LAST   = BLK_W'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WALK  = 2'd2,
        ST_FLASH = 2'd3
    } state_t;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             db_level_q, db_level_d;
    logic             db_level_prev_q, db_level_prev_d;
    logic             press_q, press_d;
    logic             green_prev_q, green_prev_d;
    logic             green_rise_s;

    state_t           state_q, state_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [BLK_W-1:0] blink_q, blink_d;
    logic             phase_q, phase_d;
    logic             pending_q, pending_d;
    logic             entry_s;

    logic             ped_req_q, ped_req_d;
    logic             walk_q, walk_d;
    logic             dont_walk_q, dont_walk_d;
    logic             buzzer_q, buzzer_d;
    logic             busy_q, busy_d;

    // Button front end: synchronizer, debounce level, one-cycle press pulse, grant edge detect.
    always_comb begin
        sync1_d         = ped_btn;
        sync2_d         = sync1_q;
        db_cnt_d        = db_cnt_q;
        db_level_d      = db_level_q;
        if (!sync2_q) begin
            db_cnt_d   = {DB_W{1'b0}};
            db_level_d = 1'b0;
        end else if (db_level_q) begin
            db_cnt_d   = {DB_W{1'b0}};
            db_level_d = 1'b1;
        end else if (db_cnt_q == DB_LAST) begin
            db_cnt_d   = {DB_W{1'b0}};
            db_level_d = 1'b1;
        end else begin
            db_cnt_d   = db_cnt_q + DB_W'(1);
            db_level_d = 1'b0;
        end
        db_level_prev_d = db_level_q;
        press_d         = db_level_q & ~db_level_prev_q;
        green_prev_d    = green_in;
        green_rise_s    = green_in & ~green_prev_q;
    end

    // Next-state, timers, pending flag and next output values.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        dur_d     = dur_q;
        blink_d   = blink_q;
        phase_d   = phase_q;

        case (state_q)
            ST_IDLE: begin
                if (press_q || pending_q) begin
                    state_d   = ST_REQ;
                    pending_d = 1'b0;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (green_rise_s) begin
                    state_d = ST_WALK;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WALK: begin
                if (press_q) begin
                    pending_d = 1'b1;
                end else begin
                    pending_d = pending_q;
                end
                if (!green_in || (dur_q == WALK_LAST)) begin
                    state_d = ST_FLASH;
                end else begin
                    state_d = ST_WALK;
                end
            end
            ST_FLASH: begin
                if (press_q) begin
                    pending_d = 1'b1;
                end else begin
                    pending_d = pending_q;
                end
                if (!green_in || (dur_q == FLASH_LAST)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FLASH;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                pending_d = 1'b0;
            end
        endcase

        // Timers restart on every state entry; the cadence phase always begins high.
        entry_s = (state_d != state_q);
        if (entry_s || (state_q == ST_IDLE) || (state_q == ST_REQ)) begin
            dur_d   = {DUR_W{1'b0}};
            blink_d = {BLK_W{1'b0}};
            phase_d = 1'b1;
        end else if (blink_q == BLK_LAST) begin
            dur_d   = dur_q + DUR_W'(1);
            blink_d = {BLK_W{1'b0}};
            phase_d = ~phase_q;
        end else begin
            dur_d   = dur_q + DUR_W'(1);
            blink_d = blink_q + BLK_W'(1);
            phase_d = phase_q;
        end

        case (state_d)
            ST_IDLE: begin
                ped_req_d = 1'b0; walk_d = 1'b0; dont_walk_d = 1'b1; buzzer_d = 1'b0; busy_d = 1'b0;
            end
            ST_REQ: begin
                ped_req_d = 1'b1; walk_d = 1'b0; dont_walk_d = 1'b1; buzzer_d = 1'b0; busy_d = 1'b0;
            end
            ST_WALK: begin
                ped_req_d = 1'b0; walk_d = 1'b1; dont_walk_d = 1'b0; buzzer_d = phase_d; busy_d = 1'b1;
            end
            ST_FLASH: begin
                ped_req_d = 1'b0; walk_d = 1'b0; dont_walk_d = phase_d; buzzer_d = 1'b0; busy_d = 1'b1;
            end
            default: begin
                ped_req_d = 1'b0; walk_d = 1'b0; dont_walk_d = 1'b1; buzzer_d = 1'b0; busy_d = 1'b0;
            end
        endcase
    end

    // All state and outputs; reset returns to a safe don't-walk idle with nothing pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q         <= 1'b0;
            sync2_q         <= 1'b0;
            db_cnt_q        <= {DB_W{1'b0}};
            db_level_q      <= 1'b0;
            db_level_prev_q <= 1'b0;
            press_q         <= 1'b0;
            green_prev_q    <= 1'b0;
            state_q         <= ST_IDLE;
            dur_q           <= {DUR_W{1'b0}};
            blink_q         <= {BLK_W{1'b0}};
            phase_q         <= 1'b1;
            pending_q       <= 1'b0;
            ped_req_q       <= 1'b0;
            walk_q          <= 1'b0;
            dont_walk_q     <= 1'b1;
            buzzer_q        <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            db_cnt_q        <= db_cnt_d;
            db_level_q      <= db_level_d;
            db_level_prev_q <= db_level_prev_d;
            press_q         <= press_d;
            green_prev_q    <= green_prev_d;
            state_q         <= state_d;
            dur_q           <= dur_d;
            blink_q         <= blink_d;
            phase_q         <= phase_d;
            pending_q       <= pending_d;
            ped_req_q       <= ped_req_d;
            walk_q          <= walk_d;
            dont_walk_q     <= dont_walk_d;
            buzzer_q        <= buzzer_d;
            busy_q          <= busy_d;
        end
    end

    assign ped_req   = ped_req_q;
    assign walk      = walk_q;
    assign dont_walk = dont_walk_q;
    assign buzzer    = buzzer_q;
    assign busy      = busy_q;

    ped_crossing_unit_chk u_chk (
        .clk       (clk),
        .reset     (reset),
        .walk      (walk_q),
        .dont_walk (dont_walk_q),
        .busy      (busy_q),
        .ped_req   (ped_req_q)
    );

endmodule
